// File: rtl/rtc_time_reader_if.sv
// Multiplexed address/data bus between the time reader (master) and the external RTC chip (slave).
interface rtc_time_reader_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       ad_sel;
    logic       wr_n;
    logic       rd_n;

    modport master (input ad_in, output ad_out, ad_oe, cs_n, ad_sel, wr_n, rd_n);
    modport slave  (output ad_in, input ad_out, ad_oe, cs_n, ad_sel, wr_n, rd_n);
endinterface

// File: rtl/rtc_time_reader.sv
// Periodically sweeps the RTC hours/minutes/seconds registers over the multiplexed bus and
// publishes the three BCD bytes atomically to the hour-digit renderer.
module rtc_time_reader #(
    parameter int         T_PHASE   = 4,
    parameter int         POLL_CYC  = 50000000,
    parameter logic [7:0] ADDR_HOUR = 8'h23,
    parameter logic [7:0] ADDR_MIN  = 8'h22,
    parameter logic [7:0] ADDR_SEC  = 8'h21
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    rtc_time_reader_if.master  bus,
    output logic [7:0]         hour_in1,
    output logic [7:0]         hour_in2,
    output logic [7:0]         hour_in3,
    output logic               okmaquina,
    output logic               upd_pulse,
    output logic               bcd_err,
    output logic               busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP1, S_READ, S_GAP2, S_UPDATE, S_WAIT
    } state_t;

    typedef enum logic [1:0] {IDX_HOUR, IDX_MIN, IDX_SEC} idx_t;

    localparam int PW = $clog2(T_PHASE);
    localparam int CW = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;

    state_t        state, state_nxt;
    idx_t          idx, idx_nxt;
    logic [PW-1:0] phase_cnt;
    logic [CW-1:0] int_cnt;
    logic [7:0]    shadow [3];

    logic          phase_last;
    logic          cnt_done;
    logic          sweep_start;

    logic [7:0]    ad_out_d;
    logic          ad_oe_d, cs_n_d, ad_sel_d, wr_n_d, rd_n_d, busy_d;

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] addr_of(input idx_t i);
        case (i)
            IDX_HOUR: return ADDR_HOUR;
            IDX_MIN:  return ADDR_MIN;
            default:  return ADDR_SEC;
        endcase
    endfunction

    assign phase_last  = (phase_cnt == PW'(T_PHASE - 1));
    assign cnt_done    = (int_cnt == CW'(POLL_CYC - 1));
    assign sweep_start = (state == S_IDLE || state == S_WAIT) && (state_nxt == S_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= IDX_HOUR;
            phase_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            phase_cnt <= (state_nxt != state) ? '0 : phase_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_ADDR;
                    idx_nxt   = IDX_HOUR;
                end
            end
            S_ADDR: if (phase_last) state_nxt = S_GAP1;
            S_GAP1: if (phase_last) state_nxt = S_READ;
            S_READ: if (phase_last) state_nxt = S_GAP2;
            S_GAP2: begin
                if (phase_last) begin
                    if (idx == IDX_SEC) begin
                        state_nxt = S_UPDATE;
                    end else begin
                        state_nxt = S_ADDR;
                        idx_nxt   = idx_t'(idx + 1'b1);
                    end
                end
            end
            S_UPDATE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt_done) begin
                    state_nxt = enable ? S_ADDR : S_IDLE;
                    idx_nxt   = IDX_HOUR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus values are decoded from the next state so the registered strobes line up with the state.
    // NOTE: every combinational output gets a default first; no path may leave one unassigned (latch).
    always_comb begin
        ad_out_d = '0;
        ad_oe_d  = 1'b0;
        cs_n_d   = 1'b1;
        ad_sel_d = 1'b0;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        busy_d   = !(state_nxt == S_IDLE || state_nxt == S_WAIT);
        case (state_nxt)
            S_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_of(idx_nxt);
            end
            S_READ: begin
                cs_n_d   = 1'b0;
                ad_sel_d = 1'b1;
                rd_n_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ad_out <= '0;
            bus.ad_oe  <= 1'b0;
            bus.cs_n   <= 1'b1;
            bus.ad_sel <= 1'b0;
            bus.wr_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            bus.ad_out <= ad_out_d;
            bus.ad_oe  <= ad_oe_d;
            bus.cs_n   <= cs_n_d;
            bus.ad_sel <= ad_sel_d;
            bus.wr_n   <= wr_n_d;
            bus.rd_n   <= rd_n_d;
            busy       <= busy_d;
        end
    end

    // Saturates at POLL_CYC-1 so short intervals give a 1-cycle WAIT instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_cnt <= '0;
        end else if (sweep_start) begin
            int_cnt <= '0;
        end else if (!cnt_done) begin
            int_cnt <= int_cnt + 1'b1;
        end
    end

    // NOTE: the shadow array is reset explicitly; UPDATE must never see power-up garbage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else if (state == S_READ && phase_last) begin
            shadow[idx] <= bus.ad_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour_in1  <= '0;
            hour_in2  <= '0;
            hour_in3  <= '0;
            okmaquina <= 1'b0;
            upd_pulse <= 1'b0;
            bcd_err   <= 1'b0;
        end else begin
            upd_pulse <= 1'b0;
            if (state == S_UPDATE) begin
                if (bcd_ok(shadow[0]) && bcd_ok(shadow[1]) && bcd_ok(shadow[2])) begin
                    hour_in1  <= shadow[0];
                    hour_in2  <= shadow[1];
                    hour_in3  <= shadow[2];
                    upd_pulse <= 1'b1;
                    okmaquina <= 1'b1;
                end else begin
                    bcd_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Directed-plus-random bench: an RTC bus model feeds two readers (normal interval and back-to-back).
module tb_rtc_time_reader;
    localparam int T_PHASE = 4;
    localparam int POLL_A  = 80;
    localparam int POLL_B  = 20;
    localparam int SWEEP   = 12 * T_PHASE;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic en_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_time_reader_if bus_a ();
    rtc_time_reader_if bus_b ();

    logic [7:0] h1_a, h2_a, h3_a, h1_b, h2_b, h3_b;
    logic       ok_a, upd_a, err_a, busy_a, ok_b, upd_b, err_b, busy_b;

    rtc_time_reader #(.T_PHASE(T_PHASE), .POLL_CYC(POLL_A)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus_a),
        .hour_in1(h1_a), .hour_in2(h2_a), .hour_in3(h3_a),
        .okmaquina(ok_a), .upd_pulse(upd_a), .bcd_err(err_a), .busy(busy_a)
    );

    rtc_time_reader #(.T_PHASE(T_PHASE), .POLL_CYC(POLL_B)) u_dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .bus(bus_b),
        .hour_in1(h1_b), .hour_in2(h2_b), .hour_in3(h3_b),
        .okmaquina(ok_b), .upd_pulse(upd_b), .bcd_err(err_b), .busy(busy_b)
    );

    // RTC chip model: latches the address on a write-strobed cycle, returns that register on read.
    logic [7:0] rtc_a_h, rtc_a_m, rtc_a_s, rtc_b_h, rtc_b_m, rtc_b_s;
    logic [7:0] lat_a = 8'h00;
    logic [7:0] lat_b = 8'h00;

    function automatic logic [7:0] rtc_lookup(input logic [7:0] a, input logic [7:0] h, m, s);
        case (a)
            8'h23:   return h;
            8'h22:   return m;
            8'h21:   return s;
            default: return 8'hEE;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!bus_a.cs_n && !bus_a.wr_n && bus_a.ad_oe) lat_a <= bus_a.ad_out;
        if (!bus_b.cs_n && !bus_b.wr_n && bus_b.ad_oe) lat_b <= bus_b.ad_out;
    end

    assign bus_a.ad_in = (!bus_a.cs_n && !bus_a.rd_n) ? rtc_lookup(lat_a, rtc_a_h, rtc_a_m, rtc_a_s) : 8'h00;
    assign bus_b.ad_in = (!bus_b.cs_n && !bus_b.rd_n) ? rtc_lookup(lat_b, rtc_b_h, rtc_b_m, rtc_b_s) : 8'h00;

    wire [12:0] bus_a_vec = {bus_a.cs_n, bus_a.ad_sel, bus_a.wr_n, bus_a.rd_n, bus_a.ad_oe, bus_a.ad_out};
    localparam logic [12:0] BUS_IDLE = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    // Reference model: published time, okmaquina and sticky error as the reader should show them.
    logic [23:0] exp_time;
    logic        exp_ok;
    logic        exp_err;

    function automatic logic is_bcd(input logic [7:0] v);
        return (int'(v) % 16 < 10) && (int'(v) / 16 < 10);
    endfunction

    function automatic logic [7:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    function automatic logic [7:0] rand_bad();
        return {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
    endfunction

    // Expected bus state k cycles after ADDR entry: 4 phases (addr, gap, read, gap) per register.
    function automatic logic [12:0] exp_bus(input int k);
        int         phase;
        int         acc;
        logic [7:0] addr;
        phase = k / T_PHASE;
        acc   = phase / 4;
        addr  = (acc == 0) ? 8'h23 : (acc == 1) ? 8'h22 : 8'h21;
        case (phase % 4)
            0:       return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, addr};
            2:       return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
            default: return BUS_IDLE;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int limit, output int t);
        int n;
        n = 0;
        while (!(bus_a.cs_n == 1'b0 && bus_a.wr_n == 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start_timeout"}, 32'(n < limit), 32'd1);
        t = cyc;
    endtask

    // Walks one sweep of reader A from its first ADDR cycle through the publish cycle.
    task automatic run_sweep(input string tag, input int drop_k);
        logic [7:0] h, m, s;
        logic       pulse;
        h = rtc_a_h;
        m = rtc_a_m;
        s = rtc_a_s;
        for (int k = 0; k < SWEEP; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_k) enable = 1'b0;
            check($sformatf("%s bus k=%0d", tag, k), 32'(bus_a_vec), 32'(exp_bus(k)));
        end
        @(negedge clk);
        check({tag, " pre_publish"}, {30'd0, upd_a, busy_a}, 32'b01);
        pulse = is_bcd(h) && is_bcd(m) && is_bcd(s);
        if (pulse) begin
            exp_time = {h, m, s};
            exp_ok   = 1'b1;
        end else begin
            exp_err  = 1'b1;
        end
        @(negedge clk);
        check({tag, " upd_pulse"}, 32'(upd_a), 32'(pulse));
        check({tag, " time"}, {8'd0, h1_a, h2_a, h3_a}, {8'd0, exp_time});
        check({tag, " ok_err_busy"}, {29'd0, ok_a, err_a, busy_a}, {29'd0, exp_ok, exp_err, 1'b0});
    endtask

    task automatic wait_upd_b(input string tag, input int limit, output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!upd_b && n < limit);
        check({tag, " upd_timeout"}, 32'(n < limit), 32'd1);
        t = cyc;
    endtask

    initial begin
        int t0, t1, lows;
        reset    = 1'b0;
        enable   = 1'b0;
        en_b     = 1'b0;
        rtc_a_h  = 8'h12;
        rtc_a_m  = 8'h34;
        rtc_a_s  = 8'h56;
        rtc_b_h  = 8'h00;
        rtc_b_m  = 8'h00;
        rtc_b_s  = 8'h00;
        exp_time = '0;
        exp_ok   = 1'b0;
        exp_err  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset bus", 32'(bus_a_vec), 32'(BUS_IDLE));
        check("reset time", {8'd0, h1_a, h2_a, h3_a}, 32'd0);
        check("reset flags", {28'd0, ok_a, upd_a, err_a, busy_a}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle hold bus", 32'(bus_a_vec), 32'(BUS_IDLE));
        check("idle hold busy", 32'(busy_a), 32'd0);

        // Fixed 12:34:56 sweep, then random valid sweeps at the poll interval.
        enable = 1'b1;
        wait_start("sweep1", 5, t0);
        run_sweep("sweep1", -1);
        for (int i = 0; i < 3; i++) begin
            rtc_a_h = rand_bcd();
            rtc_a_m = rand_bcd();
            rtc_a_s = rand_bcd();
            wait_start($sformatf("rnd%0d", i), 40, t1);
            check($sformatf("rnd%0d period", i), 32'(t1 - t0), 32'(POLL_A));
            t0 = t1;
            run_sweep($sformatf("rnd%0d", i), -1);
        end

        // Invalid BCD: no publish, sticky error; a later valid sweep publishes again.
        rtc_a_m = 8'h5A;
        wait_start("bad_min", 40, t1);
        run_sweep("bad_min", -1);
        rtc_a_m = rand_bcd();
        rtc_a_s = rand_bad();
        wait_start("bad_rnd", 40, t1);
        run_sweep("bad_rnd", -1);
        rtc_a_s = rand_bcd();
        wait_start("resume", 40, t1);
        run_sweep("resume", -1);

        // enable drops during the MIN READ phase: sweep completes, then the reader goes idle.
        rtc_a_h = rand_bcd();
        wait_start("drop", 40, t1);
        run_sweep("drop", 6 * T_PHASE + 1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus_a.cs_n) lows++;
        end
        check("drop no_cs_activity", 32'(lows), 32'd0);
        check("drop busy", 32'(busy_a), 32'd0);
        check("drop time_hold", {8'd0, h1_a, h2_a, h3_a}, {8'd0, exp_time});

        // Reset asserted in the middle of the HOUR READ phase.
        enable = 1'b1;
        wait_start("rst", 5, t1);
        repeat (2 * T_PHASE + 1) @(negedge clk);
        check("rst in_read", 32'(bus_a_vec), 32'(exp_bus(2 * T_PHASE + 1)));
        reset = 1'b0;
        #1;
        check("rst bus", 32'(bus_a_vec), 32'(BUS_IDLE));
        check("rst time", {8'd0, h1_a, h2_a, h3_a}, 32'd0);
        check("rst flags", {28'd0, ok_a, upd_a, err_a, busy_a}, 32'd0);
        exp_time = '0;
        exp_ok   = 1'b0;
        exp_err  = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        rtc_a_h = rand_bcd();
        rtc_a_m = rand_bcd();
        rtc_a_s = rand_bcd();
        wait_start("post_rst", 5, t1);
        run_sweep("post_rst", -1);
        enable = 1'b0;

        // Back-to-back reader: poll interval shorter than a sweep.
        rtc_b_h = rand_bcd();
        rtc_b_m = rand_bcd();
        rtc_b_s = rand_bcd();
        en_b = 1'b1;
        wait_upd_b("b2b0", 80, t0);
        check("b2b0 time", {8'd0, h1_b, h2_b, h3_b}, {8'd0, rtc_b_h, rtc_b_m, rtc_b_s});
        for (int i = 1; i < 4; i++) begin
            rtc_b_h = rand_bcd();
            rtc_b_m = rand_bcd();
            rtc_b_s = rand_bcd();
            wait_upd_b($sformatf("b2b%0d", i), 80, t1);
            check($sformatf("b2b%0d period", i), 32'(t1 - t0), 32'(SWEEP + 2));
            check($sformatf("b2b%0d time", i), {8'd0, h1_b, h2_b, h3_b}, {8'd0, rtc_b_h, rtc_b_m, rtc_b_s});
            check($sformatf("b2b%0d flags", i), {29'd0, ok_b, err_b, busy_b}, 32'b100);
            t0 = t1;
        end
        en_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
